// File: rtl/i2c_codec_responder.sv
// i2c_codec_responder: I2C target emulating a write-only audio codec control
// port (7-bit register address, 9-bit data). Captures writes into a local
// register file, strobes each committed write and exposes the file through a
// combinational read port.
// Optional feature macro: I2C_READ_EN (read-back of the last written register).
module i2c_codec_responder #(
    parameter logic [6:0] DEV_ADDR  = 7'h1A,
    parameter int         NUM_REGS  = 16,
    parameter logic [6:0] RESET_REG = 7'h0F
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       wr_valid,
    output logic [6:0] wr_addr,
    output logic [8:0] wr_data,
    input  logic [6:0] rd_addr,
    output logic [8:0] rd_data,
    output logic       busy
);

    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ADDR     = 4'd1,
        ST_ADDR_ACK = 4'd2,
        ST_BYTE1    = 4'd3,
        ST_ACK1     = 4'd4,
        ST_BYTE2    = 4'd5,
        ST_ACK2     = 4'd6,
        ST_IGNORE   = 4'd7,
        ST_TX       = 4'd8,
        ST_TX_ACK   = 4'd9
    } state_t;

    state_t     r_state;
    logic       r_scl_s1, r_scl_s2, r_scl_d;
    logic       r_sda_s1, r_sda_s2, r_sda_d;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic [6:0] r_reg_addr;
    logic       r_data8;
    logic       r_ack_drv;
    logic [8:0] r_regs [NUM_REGS];

    logic       w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0] w_byte;
    logic       w_addr_match, w_addr_wr, w_addr_rd, w_commit;

`ifdef I2C_READ_EN
    logic       r_rd;
    logic [6:0] r_ptr;
    logic [7:0] r_tx;
    logic       r_tx_first;
    logic       r_mack;
    logic [8:0] w_tx_reg;
`endif

    // Two-stage synchronizers plus one history stage; reset to the idle-high bus level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_scl_d  <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
            r_sda_d  <= 1'b1;
        end else begin
            r_scl_s1 <= scl_in;
            r_scl_s2 <= r_scl_s1;
            r_scl_d  <= r_scl_s2;
            r_sda_s1 <= sda_in;
            r_sda_s2 <= r_sda_s1;
            r_sda_d  <= r_sda_s2;
        end
    end

    // Bus events and byte decode, all taken from synchronized values
    always_comb begin
        w_scl_rise   = r_scl_s2 & ~r_scl_d;
        w_scl_fall   = ~r_scl_s2 & r_scl_d;
        w_start      = r_scl_s2 & r_scl_d & ~r_sda_s2 & r_sda_d;
        w_stop       = r_scl_s2 & r_scl_d & r_sda_s2 & ~r_sda_d;
        w_byte       = {r_shift[6:0], r_sda_s2};
        w_addr_match = (w_byte[7:1] == DEV_ADDR);
        w_addr_wr    = w_addr_match & ~w_byte[0];
`ifdef I2C_READ_EN
        w_addr_rd    = w_addr_match & w_byte[0];
`else
        w_addr_rd    = 1'b0;
`endif
        w_commit     = (r_state == ST_BYTE2) && w_scl_rise && (r_bit_cnt == 3'd7)
                       && !w_start && !w_stop;
    end

`ifdef I2C_READ_EN
    // Register addressed by the last committed write, used as the read-back source
    always_comb begin
        if (int'(r_ptr) < NUM_REGS) begin
            w_tx_reg = r_regs[r_ptr[IW-1:0]];
        end else begin
            w_tx_reg = 9'd0;
        end
    end
`endif

    // Protocol FSM: START/STOP override, bit shifting, ACK drive and write commit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'd0;
            r_reg_addr <= 7'd0;
            r_data8    <= 1'b0;
            r_ack_drv  <= 1'b0;
            sda_oe     <= 1'b0;
            busy       <= 1'b0;
            wr_valid   <= 1'b0;
            wr_addr    <= 7'd0;
            wr_data    <= 9'd0;
`ifdef I2C_READ_EN
            r_rd       <= 1'b0;
            r_ptr      <= 7'd0;
            r_tx       <= 8'd0;
            r_tx_first <= 1'b0;
            r_mack     <= 1'b1;
`endif
        end else begin
            wr_valid <= 1'b0;
            if (w_stop) begin
                r_state   <= ST_IDLE;
                busy      <= 1'b0;
                sda_oe    <= 1'b0;
                r_ack_drv <= 1'b0;
                r_bit_cnt <= 3'd0;
            end else if (w_start) begin
                r_state   <= ST_ADDR;
                busy      <= 1'b1;
                sda_oe    <= 1'b0;
                r_ack_drv <= 1'b0;
                r_bit_cnt <= 3'd0;
            end else begin
                case (r_state)
                    ST_ADDR, ST_BYTE1, ST_BYTE2: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_bit_cnt <= 3'd0;
                                if (r_state == ST_ADDR) begin
                                    if (w_addr_wr || w_addr_rd) begin
                                        r_state <= ST_ADDR_ACK;
                                    end else begin
                                        r_state <= ST_IGNORE;
                                    end
`ifdef I2C_READ_EN
                                    r_rd <= w_addr_rd;
`endif
                                end else if (r_state == ST_BYTE1) begin
                                    r_reg_addr <= w_byte[7:1];
                                    r_data8    <= w_byte[0];
                                    r_state    <= ST_ACK1;
                                end else begin
                                    r_state  <= ST_ACK2;
                                    wr_valid <= 1'b1;
                                    wr_addr  <= r_reg_addr;
                                    wr_data  <= {r_data8, w_byte};
`ifdef I2C_READ_EN
                                    r_ptr    <= r_reg_addr;
`endif
                                end
                            end
                        end
                    end
                    ST_ADDR_ACK, ST_ACK1, ST_ACK2: begin
                        // First SCL fall ends bit 8 (drive ACK), second ends the ACK clock
                        if (w_scl_fall) begin
                            if (!r_ack_drv) begin
                                sda_oe    <= 1'b1;
                                r_ack_drv <= 1'b1;
                            end else begin
                                sda_oe    <= 1'b0;
                                r_ack_drv <= 1'b0;
                                r_bit_cnt <= 3'd0;
                                if (r_state == ST_ADDR_ACK) begin
                                    r_state <= ST_BYTE1;
`ifdef I2C_READ_EN
                                    if (r_rd) begin
                                        r_state    <= ST_TX;
                                        r_tx       <= {7'd0, w_tx_reg[8]};
                                        sda_oe     <= 1'b1;
                                        r_tx_first <= 1'b1;
                                    end
`endif
                                end else if (r_state == ST_ACK1) begin
                                    r_state <= ST_BYTE2;
                                end else begin
                                    r_state <= ST_IGNORE;
                                end
                            end
                        end
                    end
`ifdef I2C_READ_EN
                    ST_TX: begin
                        // Transmit bits change on SCL falls; release after the 8th bit
                        if (w_scl_fall) begin
                            if (r_bit_cnt == 3'd7) begin
                                sda_oe    <= 1'b0;
                                r_bit_cnt <= 3'd0;
                                r_state   <= ST_TX_ACK;
                            end else begin
                                sda_oe    <= ~r_tx[6];
                                r_tx      <= {r_tx[6:0], 1'b0};
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end
                    end
                    ST_TX_ACK: begin
                        if (w_scl_rise) begin
                            r_mack <= r_sda_s2;
                        end
                        if (w_scl_fall) begin
                            if (!r_mack && r_tx_first) begin
                                r_tx       <= w_tx_reg[7:0];
                                sda_oe     <= ~w_tx_reg[7];
                                r_tx_first <= 1'b0;
                                r_bit_cnt  <= 3'd0;
                                r_state    <= ST_TX;
                            end else begin
                                sda_oe  <= 1'b0;
                                r_state <= ST_IGNORE;
                            end
                        end
                    end
`endif
                    ST_IDLE, ST_IGNORE: begin
                        sda_oe <= 1'b0;
                    end
                    default: begin
                        sda_oe  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Register file: clear-all on RESET_REG, in-range writes, out-of-range writes dropped
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= 9'd0;
            end
        end else if (w_commit) begin
            if (r_reg_addr == RESET_REG) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    r_regs[i] <= 9'd0;
                end
            end else if (int'(r_reg_addr) < NUM_REGS) begin
                r_regs[r_reg_addr[IW-1:0]] <= {r_data8, w_byte};
            end
        end
    end

    // Combinational read port; out-of-range addresses read as zero
    always_comb begin
        if (int'(rd_addr) < NUM_REGS) begin
            rd_data = r_regs[rd_addr[IW-1:0]];
        end else begin
            rd_data = 9'd0;
        end
    end

endmodule
